// File: rtl/kbd_pkg.sv
// Shared FSM states, status bit positions and read-select codes for the PS/2 receiver.
// KBD_BREAK_FILTER_EN widens FIFO entries to 9 bits to carry a break-prefix flag.
package kbd_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } kbd_state_e;

    localparam logic [7:0] KBD_BREAK_CODE = 8'hF0;

    localparam int ST_OVF       = 0;
    localparam int ST_FRAME     = 1;
    localparam int ST_TIMEOUT   = 2;
    localparam int ST_COUNT_LSB = 16;
    localparam int ST_VALID     = 31;

    localparam logic RD_SEL_DATA   = 1'b0;
    localparam logic RD_SEL_STATUS = 1'b1;

`ifdef KBD_BREAK_FILTER_EN
    localparam int KBD_ENTRY_W = 9;
`else
    localparam int KBD_ENTRY_W = 8;
`endif

endpackage

// File: rtl/kbd_fifo.sv
// Synchronous scancode FIFO; pointers carry one extra wrap bit so full and empty
// are told apart, and a pop in the same cycle frees the slot for a push when full.
module kbd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_pushData,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wrPtr;
    logic [AW:0]      r_rdPtr;
    logic             w_doPush;
    logic             w_doPop;

    assign o_empty  = (r_wrPtr == r_rdPtr);
    assign o_full   = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
    assign o_count  = r_wrPtr - r_rdPtr;
    assign o_head   = r_mem[r_rdPtr[AW-1:0]];
    assign w_doPop  = i_pop & ~o_empty;
    assign w_doPush = i_push & (~o_full | w_doPop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_doPush) r_mem[r_wrPtr[AW-1:0]] <= i_pushData;
    end

endmodule

// File: rtl/kbd_ctrl.sv
// PS/2 keyboard receiver: pin synchronizer and glitch filter, frame FSM, scancode FIFO, CPU read port.
// Define KBD_BREAK_FILTER_EN to fold 0xF0 break prefixes into bit 8 of the following scancode.
module kbd_ctrl
    import kbd_pkg::*;
#(
    parameter int FIFO_DEPTH     = 16,
    parameter int FILTER_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        rd_en,
    input  logic        rd_sel,
    output logic [31:0] rd_data,
    output logic        irq
);
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int FILT_W = $clog2(FILTER_CYCLES + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]             r_clkSync;
    logic [1:0]             r_dataSync;
    logic                   r_filtClk;
    logic [FILT_W-1:0]      r_filtCnt;
    logic                   r_fall;
    logic                   r_fallData;

    kbd_state_e             r_state;
    kbd_state_e             w_nextState;
    logic [7:0]             r_shreg;
    logic [2:0]             r_bitCnt;
    logic                   r_parity;
    logic [TO_W-1:0]        r_toCnt;
    logic                   r_ovf;
    logic                   r_frameErr;
    logic                   r_toErr;

    logic                   w_frameOk;
    logic                   w_frameBad;
    logic                   w_timeout;
    logic                   w_push;
    logic [KBD_ENTRY_W-1:0] w_pushData;
    logic [KBD_ENTRY_W-1:0] w_head;
    logic [8:0]             w_head9;
    logic [AW:0]            w_count;
    logic [4:0]             w_count5;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_pop;
    logic                   w_statusRd;

    // The filtered clock only follows the synchronized pin after FILTER_CYCLES disagreeing samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clkSync  <= 2'b11;
            r_dataSync <= 2'b11;
            r_filtClk  <= 1'b1;
            r_filtCnt  <= '0;
            r_fall     <= 1'b0;
            r_fallData <= 1'b0;
        end else begin
            r_clkSync  <= {r_clkSync[0], ps2_clk};
            r_dataSync <= {r_dataSync[0], ps2_data};
            r_fall     <= 1'b0;
            if (r_clkSync[1] == r_filtClk) begin
                r_filtCnt <= '0;
            end else if (r_filtCnt == FILT_W'(FILTER_CYCLES - 1)) begin
                r_filtClk  <= r_clkSync[1];
                r_filtCnt  <= '0;
                r_fall     <= r_filtClk;
                r_fallData <= r_dataSync[1];
            end else begin
                r_filtCnt <= r_filtCnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        w_frameOk   = 1'b0;
        w_frameBad  = 1'b0;
        w_timeout   = 1'b0;
        if (r_state != S_IDLE && !r_fall && r_toCnt >= TO_W'(TIMEOUT_CYCLES)) begin
            w_timeout   = 1'b1;
            w_nextState = S_IDLE;
        end else if (r_fall) begin
            case (r_state)
                S_IDLE:   if (!r_fallData) w_nextState = S_DATA;
                S_DATA:   if (r_bitCnt == 3'd7) w_nextState = S_PARITY;
                S_PARITY: w_nextState = S_STOP;
                S_STOP: begin
                    w_nextState = S_IDLE;
                    if (r_fallData && (^{r_shreg, r_parity})) w_frameOk  = 1'b1;
                    else                                      w_frameBad = 1'b1;
                end
                default:  w_nextState = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shreg  <= '0;
            r_bitCnt <= '0;
            r_parity <= 1'b0;
            r_toCnt  <= '0;
        end else begin
            if (r_state == S_IDLE || r_fall || w_timeout) r_toCnt <= '0;
            else                                          r_toCnt <= r_toCnt + 1'b1;
            if (r_fall) begin
                case (r_state)
                    S_IDLE:   r_bitCnt <= '0;
                    S_DATA: begin
                        r_shreg  <= {r_fallData, r_shreg[7:1]};
                        r_bitCnt <= r_bitCnt + 1'b1;
                    end
                    S_PARITY: r_parity <= r_fallData;
                    default:  ;
                endcase
            end
        end
    end

`ifdef KBD_BREAK_FILTER_EN
    logic r_break;

    assign w_push     = w_frameOk && (r_shreg != KBD_BREAK_CODE);
    assign w_pushData = {r_break, r_shreg};
    assign w_head9    = w_head;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                          r_break <= 1'b0;
        else if (w_frameOk && r_shreg == KBD_BREAK_CODE)   r_break <= 1'b1;
        else if (w_push || w_frameBad || w_timeout)        r_break <= 1'b0;
    end
`else
    assign w_push     = w_frameOk;
    assign w_pushData = r_shreg;
    assign w_head9    = {1'b0, w_head};
`endif

    assign w_pop      = rd_en & (rd_sel == RD_SEL_DATA) & ~w_empty;
    assign w_statusRd = rd_en & (rd_sel == RD_SEL_STATUS);

    // Sticky flags: a set in the same cycle as a status read takes priority over the clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf      <= 1'b0;
            r_frameErr <= 1'b0;
            r_toErr    <= 1'b0;
        end else begin
            r_ovf      <= (w_push & w_full & ~w_pop) | (r_ovf & ~w_statusRd);
            r_frameErr <= w_frameBad | (r_frameErr & ~w_statusRd);
            r_toErr    <= w_timeout | (r_toErr & ~w_statusRd);
        end
    end

    kbd_fifo #(
        .WIDTH (KBD_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_pushData (w_pushData),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_count    (w_count),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    assign irq      = ~w_empty;
    assign w_count5 = 5'(w_count);

    always_comb begin
        rd_data = '0;
        if (rd_sel == RD_SEL_STATUS) begin
            rd_data[ST_VALID]            = ~w_empty;
            rd_data[ST_COUNT_LSB +: 5]   = w_count5;
            rd_data[ST_TIMEOUT]          = r_toErr;
            rd_data[ST_FRAME]            = r_frameErr;
            rd_data[ST_OVF]              = r_ovf;
        end else if (!w_empty) begin
            rd_data[ST_VALID]            = 1'b1;
            rd_data[8:0]                 = w_head9;
        end
    end

endmodule
